ram_req_master: RTL

Initiator-side adapter that turns a valid/ready request stream (read or write, one per beat) into accesses on a single-port synchronous RAM port: enable, write-enable, address, write data, and read data one cycle later. It absorbs the RAM's fixed one-cycle read latency and downstream backpressure with a 2-entry response FIFO, so a CPU bus bridge or DMA engine never has to track RAM timing. It sits between the system fabric and each on-chip RAM instance.

---
 rtl/ram_req_master.sv | 63 ++++++
 1 files changed

// File: rtl/ram_req_master.sv
// ram_req_master: valid/ready request stream to single-port sync RAM, with a 2-entry read response FIFO.
module ram_req_master #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  input  logic [DATA_BITS-1:0] ram_dout,
  output logic                 busy
);
  logic [1:0] count_q, count_d;
  logic wptr_q, wptr_d, rptr_q, rptr_d, inflight_q, inflight_d;
  logic [DATA_BITS-1:0] mem_q [2];
  logic accept, pop, push;
  logic [2:0] occ;
  // Credit covers the in-flight read so a full FIFO is never pushed; a pop this cycle frees a slot.
  always_comb begin
    pop = !rst && count_q != 2'd0 && rsp_ready;
    push = inflight_q;
    occ = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    req_ready = !rst && occ < 3'd2;
    accept = req_valid && req_ready;
    ram_ena = accept;
    ram_wea = accept && req_we;
    ram_addr = req_addr;
    ram_din = req_wdata;
    rsp_valid = !rst && count_q != 2'd0;
    rsp_rdata = rst ? '0 : mem_q[rptr_q];
    busy = !rst && (inflight_q || count_q != 2'd0);
    inflight_d = accept && !req_we;
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      inflight_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      inflight_q <= inflight_d;
      if (push) mem_q[wptr_q] <= ram_dout;
    end
  end
endmodule
